// File: rtl/ssp_pkg.sv
// rtl/ssp_pkg.sv - shared types and default constants for the SSP host blocks
package ssp_pkg;

   localparam int SSP_NREQ       = 4;
   localparam int SSP_FIFO_DEPTH = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_WGAP  = 3'd2,
      ST_READ  = 3'd3,
      ST_RCAP  = 3'd4
   } ssp_sched_state_t;

endpackage

// File: rtl/ssp_rr_arbiter.sv
// rtl/ssp_rr_arbiter.sv - round-robin winner select with registered last-grant pointer
module ssp_rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic                    pclk,
   input  logic                    clear,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         gnt,
   output logic                    win_valid,
   output logic [$clog2(NREQ)-1:0] win_idx,
   output logic [NREQ-1:0]         win_onehot
);

   localparam int IDXW = $clog2(NREQ);

   logic [IDXW-1:0] last_gnt_q;
   logic [IDXW-1:0] last_gnt_d;

   // Search one past the last granted requester, wrapping, first requester found wins.
   always_comb begin
      int              k;
      logic [IDXW-1:0] kk;
      k          = 0;
      kk         = '0;
      win_valid  = 1'b0;
      win_idx    = '0;
      win_onehot = '0;
      for (int i = 1; i <= NREQ; i++) begin
         k  = (int'(last_gnt_q) + i) % NREQ;
         kk = IDXW'(k);
         if (!win_valid && req[kk]) begin
            win_valid      = 1'b1;
            win_idx        = kk;
            win_onehot[kk] = 1'b1;
         end
      end
   end

   // The pointer only moves when a grant pulse is actually issued.
   always_comb begin
      last_gnt_d = last_gnt_q;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            last_gnt_d = IDXW'(i);
         end
      end
   end

   // Pointer register; resets to the last requester so requester 0 wins first.
   always_ff @(posedge pclk or posedge clear) begin
      if (clear) begin
         last_gnt_q <= IDXW'(NREQ - 1);
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

endmodule

// File: rtl/ssp_host_sched.sv
// rtl/ssp_host_sched.sv - SSP write-port arbiter and receive FIFO drain scheduler
module ssp_host_sched
   import ssp_pkg::*;
#(
   parameter int NREQ       = SSP_NREQ,
   parameter int FIFO_DEPTH = SSP_FIFO_DEPTH
) (
   input  logic                pclk,
   input  logic                clear,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*8-1:0]   wdata,
   output logic [NREQ-1:0]     gnt,
   output logic                ssp_psel,
   output logic                ssp_pwrite,
   output logic [7:0]          ssp_pwdata,
   input  logic                ssp_txintr,
   input  logic                ssp_rxintr,
   input  logic [7:0]          ssp_prdata,
   output logic [7:0]          rx_data,
   output logic                rx_valid,
   output logic                busy
);

   localparam int IDXW = $clog2(NREQ);
   localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

   ssp_sched_state_t state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic             psel_q, psel_d;
   logic             pwrite_q, pwrite_d;
   logic [7:0]       pwdata_q, pwdata_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             busy_q, busy_d;
   logic [CNTW-1:0]  rx_cnt_q, rx_cnt_d;

   logic             win_valid;
   logic [IDXW-1:0]  win_idx;
   logic [NREQ-1:0]  win_onehot;

   ssp_rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .pclk       (pclk),
      .clear      (clear),
      .req        (req),
      .gnt        (gnt_q),
      .win_valid  (win_valid),
      .win_idx    (win_idx),
      .win_onehot (win_onehot)
   );

   // Next state and next output values; strobes default low so each lasts one cycle.
   always_comb begin
      logic [CNTW-1:0] cnt_dec;
      cnt_dec    = rx_cnt_q - CNTW'(1);
      state_d    = state_q;
      gnt_d      = '0;
      psel_d     = 1'b0;
      pwrite_d   = 1'b0;
      pwdata_d   = pwdata_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_cnt_d   = rx_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (ssp_rxintr) begin
               state_d  = ST_READ;
               rx_cnt_d = CNTW'(FIFO_DEPTH);
               psel_d   = 1'b1;
            end else if (win_valid && !ssp_txintr) begin
               state_d  = ST_WRITE;
               psel_d   = 1'b1;
               pwrite_d = 1'b1;
               gnt_d    = win_onehot;
               pwdata_d = wdata[{win_idx, 3'b000} +: 8];
            end
         end
         ST_WRITE: state_d = ST_WGAP;
         ST_WGAP:  state_d = ST_IDLE;
         ST_READ:  state_d = ST_RCAP;
         ST_RCAP: begin
            rx_data_d  = ssp_prdata;
            rx_valid_d = 1'b1;
            rx_cnt_d   = cnt_dec;
            if (cnt_dec == '0) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_READ;
               psel_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge pclk or posedge clear) begin
      if (clear) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         psel_q     <= 1'b0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= 8'h00;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         rx_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         psel_q     <= psel_d;
         pwrite_q   <= pwrite_d;
         pwdata_q   <= pwdata_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
         rx_cnt_q   <= rx_cnt_d;
      end
   end

   assign gnt        = gnt_q;
   assign ssp_psel   = psel_q;
   assign ssp_pwrite = pwrite_q;
   assign ssp_pwdata = pwdata_q;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_ssp_host_sched.sv
// tb/tb_ssp_host_sched.sv - self-checking bench for ssp_host_sched
module tb_ssp_host_sched;

   localparam int NREQ = 4;
   localparam int FD   = 4;

   logic            pclk = 1'b0;
   logic            clear;
   logic [NREQ-1:0] req;
   logic [31:0]     wdata;
   logic [NREQ-1:0] gnt;
   logic            ssp_psel, ssp_pwrite;
   logic [7:0]      ssp_pwdata;
   logic            ssp_txintr, ssp_rxintr;
   logic [7:0]      ssp_prdata;
   logic [7:0]      rx_data;
   logic            rx_valid, busy;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   logic [7:0] rd_vals[$];

   ssp_host_sched #(.NREQ(NREQ), .FIFO_DEPTH(FD)) dut (
      .pclk       (pclk),
      .clear      (clear),
      .req        (req),
      .wdata      (wdata),
      .gnt        (gnt),
      .ssp_psel   (ssp_psel),
      .ssp_pwrite (ssp_pwrite),
      .ssp_pwdata (ssp_pwdata),
      .ssp_txintr (ssp_txintr),
      .ssp_rxintr (ssp_rxintr),
      .ssp_prdata (ssp_prdata),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .busy       (busy)
   );

   always #5 pclk = ~pclk;

   // Reference model: op 0 = idle, 1 = transmit (2 cycles), 2 = drain (2*FD cycles).
   int         m_op = 0, m_pos = 0, m_last = NREQ - 1, m_w = 0;
   logic [7:0] m_b = 8'h00, m_rxd = 8'h00;
   bit         m_rxv = 1'b0;

   initial begin
      forever begin
         @(posedge pclk or posedge clear);
         if (clear) begin
            m_op = 0; m_pos = 0; m_last = NREQ - 1; m_w = 0;
            m_b = 8'h00; m_rxd = 8'h00; m_rxv = 1'b0;
         end else begin
            m_rxv = 1'b0;
            if (m_op == 2 && (m_pos % 2) == 1) begin
               m_rxv = 1'b1;
               m_rxd = ssp_prdata;
            end
            if (m_op != 0) begin
               m_pos++;
               if ((m_op == 1 && m_pos == 2) || (m_op == 2 && m_pos == 2 * FD)) m_op = 0;
            end else if (ssp_rxintr) begin
               m_op = 2; m_pos = 0;
            end else if (req != '0 && !ssp_txintr) begin
               bit found;
               found = 1'b0;
               for (int i = 1; i <= NREQ; i++) begin
                  int k;
                  k = (m_last + i) % NREQ;
                  if (!found && req[k[1:0]]) begin
                     found = 1'b1;
                     m_w   = k;
                  end
               end
               m_last = m_w;
               m_b    = wdata[8 * m_w +: 8];
               m_op   = 1; m_pos = 0;
            end
         end
      end
   end

   // Every cycle: compare the whole output bundle against the model.
   bit prev_psel = 1'b0;
   initial begin
      forever begin
         @(negedge pclk);
         if (chk_en) begin
            logic [23:0] got, exp;
            logic [3:0]  e_gnt;
            bit          e_psel, e_pwrite, e_busy;
            e_psel   = (m_op == 1 && m_pos == 0) || (m_op == 2 && (m_pos % 2) == 0);
            e_pwrite = (m_op == 1 && m_pos == 0);
            e_gnt    = e_pwrite ? (4'b0001 << m_w) : 4'b0000;
            e_busy   = (m_op != 0);
            got = {gnt, ssp_psel, ssp_pwrite, ssp_pwdata, rx_data, rx_valid, busy};
            exp = {e_gnt, e_psel, e_pwrite, m_b, m_rxd, m_rxv, e_busy};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, got, exp);
            end
            if (prev_psel) begin
               checks++;
               if (ssp_psel) begin
                  errors++;
                  $display("FAIL psel_back_to_back t=%0t got psel=1 expected 0", $time);
               end
            end
         end
         prev_psel = ssp_psel;
      end
   end

   // SSP read-data side: a read strobe this cycle presents the next byte for the next cycle.
   initial begin
      ssp_prdata = 8'h00;
      forever begin
         @(negedge pclk);
         if (ssp_psel && !ssp_pwrite) begin
            if (rd_vals.size() > 0) ssp_prdata = rd_vals.pop_front();
            else                    ssp_prdata = 8'($urandom);
         end
      end
   end

   task automatic tick();
      @(negedge pclk);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [31:0] wdata;
      logic [3:0]  exp_gnt;
      logic [7:0]  exp_pwdata;
      int          exp_wait;
   } vec_t;

   vec_t tbl[15];

   initial begin
      int         n;
      int         nrd;
      int         nrx;
      logic [7:0] got_q[$];
      logic [31:0] w;

      w = 32'h1312_1110;
      tbl[0]  = '{4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5, 1};
      tbl[1]  = '{4'b1111, w, 4'b1000, 8'h13, 3};
      tbl[2]  = '{4'b1111, w, 4'b0001, 8'h10, 3};
      tbl[3]  = '{4'b1111, w, 4'b0010, 8'h11, 3};
      tbl[4]  = '{4'b1111, w, 4'b0100, 8'h12, 3};
      tbl[5]  = '{4'b1111, w, 4'b1000, 8'h13, 3};
      tbl[6]  = '{4'b1111, w, 4'b0001, 8'h10, 3};
      tbl[7]  = '{4'b1101, w, 4'b0100, 8'h12, 3};
      tbl[8]  = '{4'b1101, w, 4'b1000, 8'h13, 3};
      tbl[9]  = '{4'b1101, w, 4'b0001, 8'h10, 3};
      tbl[10] = '{4'b1101, w, 4'b0100, 8'h12, 3};
      tbl[11] = '{4'b0001, w, 4'b0001, 8'h10, 3};
      tbl[12] = '{4'b0001, w, 4'b0001, 8'h10, 3};
      tbl[13] = '{4'b1000, w, 4'b1000, 8'h13, 3};
      tbl[14] = '{4'b0110, w, 4'b0010, 8'h11, 3};

      clear = 1'b1; req = '0; wdata = '0; ssp_txintr = 1'b0; ssp_rxintr = 1'b0;
      chk_en = 1'b1;
      repeat (3) tick();
      chk("reset_outputs", {8'h0, gnt, ssp_psel, ssp_pwrite, ssp_pwdata, rx_data, rx_valid, busy}, 32'h0);
      clear = 1'b0;
      tick();

      // Transmit table: grant order, captured byte and latency.
      for (int e = 0; e < 15; e++) begin
         req = tbl[e].req; wdata = tbl[e].wdata; n = 0;
         do begin
            tick(); n++;
         end while (gnt == '0 && n < 8);
         chk($sformatf("tx%0d_gnt", e), {28'h0, gnt}, {28'h0, tbl[e].exp_gnt});
         chk($sformatf("tx%0d_pwdata", e), {24'h0, ssp_pwdata}, {24'h0, tbl[e].exp_pwdata});
         chk($sformatf("tx%0d_strobe", e), {30'h0, ssp_psel, ssp_pwrite}, 32'h3);
         chk($sformatf("tx%0d_wait", e), n, tbl[e].exp_wait);
      end
      req = '0;
      repeat (4) tick();

      // Backpressure: TxFIFO full blocks all grants, then released.
      ssp_txintr = 1'b1; req = 4'b0001; wdata = 32'h0000_0077; n = 0;
      repeat (20) begin
         tick();
         if (ssp_psel || gnt != '0) n++;
      end
      chk("backpressure_quiet", n, 0);
      ssp_txintr = 1'b0; n = 0;
      do begin
         tick(); n++;
      end while (gnt == '0 && n < 8);
      chk("backpressure_release_gnt", {28'h0, gnt}, 32'h1);
      chk("backpressure_release_wait", n, 1);
      req = '0;
      repeat (4) tick();

      // Drain burst with known read data.
      rd_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      got_q.delete(); nrd = 0;
      ssp_rxintr = 1'b1;
      for (int c = 0; c < 14; c++) begin
         tick();
         if (c == 0) ssp_rxintr = 1'b0;
         if (ssp_psel && !ssp_pwrite) nrd++;
         if (rx_valid) got_q.push_back(rx_data);
      end
      chk("drain_reads", nrd, FD);
      chk("drain_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] ev;
         ev = 8'((i + 1) * 8'h11);
         chk($sformatf("drain_byte%0d", i), {24'h0, (i < got_q.size()) ? got_q[i] : 8'hXX}, {24'h0, ev});
      end
      chk("drain_idle", {31'h0, busy}, 32'h0);

      // Receive wins over a simultaneous request; the request is served afterwards.
      ssp_rxintr = 1'b1; req = 4'b0010; wdata = 32'h0000_5A00; nrx = 0; n = 0;
      do begin
         tick(); n++;
         ssp_rxintr = 1'b0;
         if (rx_valid) nrx++;
      end while (gnt == '0 && n < 30);
      chk("prio_gnt", {28'h0, gnt}, 32'h2);
      chk("prio_drain_first", nrx, FD);
      chk("prio_pwdata", {24'h0, ssp_pwdata}, 32'h5A);
      req = '0;
      repeat (4) tick();

      // Reset in the middle of a drain.
      ssp_rxintr = 1'b1; nrx = 0; n = 0;
      do begin
         tick(); n++;
         ssp_rxintr = 1'b0;
         if (rx_valid) nrx++;
      end while (nrx < 2 && n < 20);
      chk("midreset_reached", nrx, 2);
      #2 clear = 1'b1;
      #1 chk("midreset_outputs", {8'h0, gnt, ssp_psel, ssp_pwrite, ssp_pwdata, rx_data, rx_valid, busy}, 32'h0);
      tick();
      #2 clear = 1'b0;
      rd_vals.delete();
      nrx = 0;
      repeat (20) begin
         tick();
         if (rx_valid) nrx++;
      end
      chk("midreset_no_rx", nrx, 0);

      // Randomized traffic against the model.
      repeat (400) begin
         tick();
         req        = 4'($urandom);
         wdata      = $urandom;
         ssp_txintr = ($urandom_range(0, 3) == 0);
         ssp_rxintr = ($urandom_range(0, 15) == 0);
      end
      req = '0; ssp_txintr = 1'b0; ssp_rxintr = 1'b0;
      repeat (12) tick();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
